// File: rtl/disp_pkg.sv
// Shared constants and BCD-to-segment decode for the multiplexed seven-segment display.
// All segment patterns are active-low in the order {g,f,e,d,c,b,a}.
package disp_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Codes above 9 decode to an unlit digit rather than a garbage pattern.
    function automatic logic [6:0] bcd2seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus: digit data and controls from the producer, pin-level drive toward the display.
// The producer side is master; the scan driver is slave.
interface seg_scan_driver_if;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_en;
    logic        blank_lz;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output digits_in, dp_in, blink_en, blank_lz, load,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  digits_in, dp_in, blink_en, blank_lz, load,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/scan_timer.sv
// Time base for the scanner: digit-slot prescaler with its terminal tick, the anti-ghosting
// dead-time window at the start of each slot, and the free-running blink phase.
module scan_timer #(
    parameter int SCAN_DIV    = 100_000,
    parameter int DEAD_CYCLES = 16,
    parameter int BLINK_DIV   = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic dead,
    output logic blink_phase
);

    localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_END  = PW'(DEAD_CYCLES);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    always_comb begin
        presc_d       = presc_q + PW'(1);
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
        end
        if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign tick        = (presc_q == PRESC_MAX);
    assign dead        = (presc_q < DEAD_END);
    assign blink_phase = blink_phase_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode display scanner: double-buffered digit data, per-slot blanking
// (dead time, blink, leading zeros) and fully registered pin outputs.
module seg_scan_driver
    import disp_pkg::*;
#(
    parameter int SCAN_DIV    = 100_000,
    parameter int DEAD_CYCLES = 16,
    parameter int BLINK_DIV   = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_driver_if.slave   bus
);

    logic tick;
    logic dead;
    logic blink_phase;

    scan_timer #(
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .BLINK_DIV   (BLINK_DIV)
    ) u_scan_timer (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .dead        (dead),
        .blink_phase (blink_phase)
    );

    logic [1:0]            index_q, index_d;
    logic [15:0]           pend_dig_q, pend_dig_d;
    logic [3:0]            pend_dp_q, pend_dp_d;
    logic [15:0]           act_dig_q, act_dig_d;
    logic [3:0]            act_dp_q, act_dp_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic                  boundary;
    logic [NUM_DIGITS-1:0] nib_zero;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] digit_blank;
    logic [3:0]            cur_nib;
    logic                  lz_run;
    logic                  show;

    assign boundary = tick && (index_q == 2'd3);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib_zero[gi]    = (act_dig_q[gi*4 +: 4] == 4'd0);
            assign digit_blank[gi] = (bus.blink_en[gi] & blink_phase) | lz_blank[gi];
        end
    endgenerate

    // A zero is only suppressed while every digit to its left is also suppressed.
    always_comb begin
        lz_blank = '0;
        lz_run   = bus.blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run & nib_zero[i];
            lz_blank[i] = lz_run;
        end
    end

    always_comb begin
        index_d      = index_q;
        pend_dig_d   = pend_dig_q;
        pend_dp_d    = pend_dp_q;
        act_dig_d    = act_dig_q;
        act_dp_d     = act_dp_q;
        frame_done_d = boundary;

        if (tick) begin
            index_d = index_q + 2'd1;
        end
        if (bus.load) begin
            pend_dig_d = bus.digits_in;
            pend_dp_d  = bus.dp_in;
        end
        // A load coinciding with the frame boundary bypasses the shadow so it shows this frame.
        if (boundary) begin
            act_dig_d = bus.load ? bus.digits_in : pend_dig_q;
            act_dp_d  = bus.load ? bus.dp_in     : pend_dp_q;
        end
    end

    always_comb begin
        cur_nib = act_dig_q[{index_q, 2'b00} +: 4];
        show    = !dead && !digit_blank[index_q];
        an_d    = AN_OFF;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        if (show) begin
            an_d  = ~(4'b0001 << index_q);
            seg_d = bcd2seg(cur_nib);
            dp_d  = ~act_dp_q[index_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_q      <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            index_q      <= index_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a cycle-count based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seg_scan_driver;

    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BD = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_driver_if bus_if ();

    seg_scan_driver #(
        .SCAN_DIV    (SD),
        .DEAD_CYCLES (DC),
        .BLINK_DIV   (BD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: everything derives from n = cycles since reset release.
    logic [6:0]  seg_tab [0:9];
    int          n;
    logic        model_ok = 1'b0;
    logic [15:0] m_pd, m_ad;
    logic [3:0]  m_pp, m_ap;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    int          slot, ph, bph;
    logic        lzb, blk;
    logic [3:0]  nib;

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        forever begin
            @(posedge clk);
            if (rst) begin
                n = 0; m_pd = '0; m_ad = '0; m_pp = '0; m_ap = '0;
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
                model_ok = 1'b1;
            end else if (model_ok) begin
                slot = (n / SD) % 4;
                ph   = n % SD;
                bph  = (n / BD) % 2;
                lzb  = 1'b0;
                if (bus_if.blank_lz && slot > 0) begin
                    lzb = 1'b1;
                    for (int k = slot; k < 4; k++) if (m_ad[k*4 +: 4] != 4'd0) lzb = 1'b0;
                end
                blk = lzb || (bus_if.blink_en[slot] && bph == 1);
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
                if (ph >= DC && !blk) begin
                    e_an[slot] = 1'b0;
                    nib   = m_ad[slot*4 +: 4];
                    e_seg = (nib <= 4'd9) ? seg_tab[nib] : 7'h7F;
                    e_dp  = ~m_ap[slot];
                end
                e_fd = (ph == SD - 1) && (slot == 3);
                if (e_fd) begin
                    m_ad = bus_if.load ? bus_if.digits_in : m_pd;
                    m_ap = bus_if.load ? bus_if.dp_in     : m_pp;
                end
                if (bus_if.load) begin
                    m_pd = bus_if.digits_in;
                    m_pp = bus_if.dp_in;
                end
                n++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok)
                check("cycle", {19'd0, bus_if.an, bus_if.seg, bus_if.dp, bus_if.frame_done},
                      {19'd0, e_an, e_seg, e_dp, e_fd});
        end
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        bus_if.digits_in = d;
        bus_if.dp_in     = p;
        bus_if.load      = 1'b1;
        @(negedge clk);
        bus_if.load      = 1'b0;
        $display("load digits=%h dp=%b", d, p);
    endtask

    task automatic wait_fd();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_if.frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_pins(input string name, input logic [3:0] an, input logic [6:0] seg,
                              input logic dp);
        check(name, {20'd0, bus_if.an, bus_if.seg, bus_if.dp}, {20'd0, an, seg, dp});
    endtask

    int c_a, c_b, c_c, c_bad;

    initial begin
        bus_if.digits_in = '0;
        bus_if.dp_in     = '0;
        bus_if.blink_en  = '0;
        bus_if.blank_lz  = 1'b0;
        bus_if.load      = 1'b0;

        // 1: reset and release
        repeat (3) @(negedge clk);
        check_pins("reset_state", 4'hF, 7'h7F, 1'b1);
        rst = 1'b0;
        @(negedge clk); check_pins("dead_c1", 4'hF, 7'h7F, 1'b1);
        @(negedge clk); check_pins("dead_c2", 4'hF, 7'h7F, 1'b1);
        @(negedge clk); check_pins("first_slot0", 4'b1110, 7'b1000000, 1'b1);

        // 2: basic load
        do_load(16'h1234, 4'b0100);
        wait_fd();
        repeat (3) @(negedge clk);
        check_pins("t2_slot0", 4'b1110, 7'b0011001, 1'b1);
        repeat (16) @(negedge clk);
        check_pins("t2_slot2", 4'b1011, 7'b0100100, 1'b0);

        // 3: leading-zero blanking
        bus_if.blank_lz = 1'b1;
        do_load(16'h0007, 4'b0000);
        wait_fd();
        c_a = 0; c_bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus_if.an == 4'b1110 && bus_if.seg == 7'b1111000) c_a++;
            else if (bus_if.an != 4'hF) c_bad++;
        end
        check("t3_d0_cycles", c_a, 6);
        check("t3_other_anodes", c_bad, 0);

        do_load(16'h0050, 4'b0000);
        wait_fd();
        c_a = 0; c_b = 0; c_bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus_if.an == 4'b1101 && bus_if.seg == 7'b0010010) c_a++;
            if (bus_if.an == 4'b1110 && bus_if.seg == 7'b1000000) c_b++;
            if (bus_if.an[3] == 1'b0 || bus_if.an[2] == 1'b0) c_bad++;
        end
        check("t3b_d1_cycles", c_a, 6);
        check("t3b_d0_cycles", c_b, 6);
        check("t3b_d3d2_lit", c_bad, 0);
        bus_if.blank_lz = 1'b0;

        // 4: blinking on digits 3 and 2
        bus_if.blink_en = 4'b1100;
        do_load(16'h1259, 4'b0000);
        wait_fd();
        c_a = 0; c_b = 0; c_c = 0;
        for (int i = 0; i < 2 * BD; i++) begin
            @(negedge clk);
            if (bus_if.an == 4'b0111) c_a++;
            if (bus_if.an == 4'b1011) c_b++;
            if (bus_if.an == 4'b1110) c_c++;
        end
        check("t4_d3_cycles", c_a, 12);
        check("t4_d2_cycles", c_b, 12);
        check("t4_d0_cycles", c_c, 24);
        bus_if.blink_en = 4'b0000;

        // 5: load exactly on the frame boundary
        do_load(16'h1234, 4'b0000);
        wait_fd();
        repeat (31) @(negedge clk);
        bus_if.digits_in = 16'h9999;
        bus_if.dp_in     = 4'b0000;
        bus_if.load      = 1'b1;
        @(negedge clk);
        bus_if.load      = 1'b0;
        $display("boundary load digits=9999");
        check("t5_boundary_fd", {31'd0, bus_if.frame_done}, 32'd1);
        repeat (3) @(negedge clk);
        check_pins("t5_slot0", 4'b1110, 7'b0010000, 1'b1);

        // 6: non-BCD nibble, then reset mid-frame
        do_load(16'h34C1, 4'b0010);
        wait_fd();
        repeat (11) @(negedge clk);
        check_pins("t6_slot1_nonbcd", 4'b1101, 7'b1111111, 1'b0);
        repeat (8) @(negedge clk);
        check_pins("t6_slot2", 4'b1011, 7'b0011001, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_pins("t6_mid_reset", 4'hF, 7'h7F, 1'b1);
        check("t6_mid_reset_fd", {31'd0, bus_if.frame_done}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
